// File: rtl/tt_rx_pkg.sv
// Shared types for the TT ingress window filter: FSM states and the window table entry.
package tt_rx_pkg;

   typedef enum logic [2:0] {
      ST_IDLE,
      ST_LOOKUP,
      ST_HEAD,
      ST_FWD,
      ST_DROP
   } tt_state_e;

   localparam int TT_PORT_W = 4;
   localparam int TT_BUF_W  = 4;
   localparam int TT_TIME_W = 64;

   typedef struct packed {
      logic                 valid;
      logic [TT_PORT_W-1:0] port;
      logic [TT_BUF_W-1:0]  buffer;
      logic [TT_TIME_W-1:0] win_start;
      logic [TT_TIME_W-1:0] win_end;
   } tt_entry_t;

endpackage

// File: rtl/tt_window_table.sv
// Per-flow receive window table: 2**FLOW_W entries, one synchronous write port, one combinational read port.
// Entry layout is a type parameter so the top can widen fields; reset invalidates every entry.
module tt_window_table
   import tt_rx_pkg::*;
#(
   parameter int  FLOW_W  = 4,
   parameter type entry_t = tt_entry_t
) (
   input  logic              clk,
   input  logic              rst_n,
   input  logic              wr_en,
   input  logic [FLOW_W-1:0] wr_addr,
   input  entry_t            wr_entry,
   input  logic [FLOW_W-1:0] rd_addr,
   output entry_t            rd_entry
);

   localparam int DEPTH = 2**FLOW_W;

   entry_t mem [DEPTH];

   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         for (int i = 0; i < DEPTH; i++) mem[i] <= '0;
      end else if (wr_en) begin
         mem[wr_addr] <= wr_entry;
      end
   end

   assign rd_entry = mem[rd_addr];

endmodule

// File: rtl/tt_rx_window_filter.sv
// TT ingress filter: forwards frames whose header arrives inside the flow's window, drops the rest.
// Latency: header 3 cycles to out_buffer_wr, body words 1 cycle; stats counters only with RX_WINDOW_STATS_EN.
// Backpressure: in_buffer_rdy stalls HEAD and gates out_tt_rdy in FWD; table writes blocked during LOOKUP.
module tt_rx_window_filter
   import tt_rx_pkg::*;
#(
   parameter int DATA_W = 64,
   parameter int CTRL_W = 8,
   parameter int TIME_W = 64,
   parameter int FLOW_W = 4,
   parameter int PORT_W = 4,
   parameter int BUF_W  = 4,
   parameter int CNT_W  = 32
) (
   input  logic              clk,
   input  logic              rst_n,
   input  logic [DATA_W-1:0] in_tt_data,
   input  logic [CTRL_W-1:0] in_tt_ctrl,
   input  logic              in_tt_wr,
   output logic              out_tt_rdy,
   output logic [DATA_W-1:0] out_buffer_data,
   output logic [CTRL_W-1:0] out_buffer_ctrl,
   output logic              out_buffer_wr,
   input  logic              in_buffer_rdy,
   output logic [PORT_W-1:0] out_switch_port,
   output logic [BUF_W-1:0]  out_switch_buffer,
   input  logic [TIME_W-1:0] in_global_time,
   input  logic              in_table_wr,
   output logic              out_table_rdy,
   input  logic [FLOW_W-1:0] in_table_flow,
   input  logic              in_table_valid,
   input  logic [PORT_W-1:0] in_port_number,
   input  logic [BUF_W-1:0]  in_buffer_number,
   input  logic [TIME_W-1:0] in_window_start,
   input  logic [TIME_W-1:0] in_window_end,
   output logic              out_drop,
   output logic [CNT_W-1:0]  out_pass_cnt,
   output logic [CNT_W-1:0]  out_early_cnt,
   output logic [CNT_W-1:0]  out_late_cnt
);

   typedef struct packed {
      logic              valid;
      logic [PORT_W-1:0] port;
      logic [BUF_W-1:0]  buffer;
      logic [TIME_W-1:0] win_start;
      logic [TIME_W-1:0] win_end;
   } entry_t;

   tt_state_e         state_q, state_d;
   logic              run_q;
   logic [DATA_W-1:0] hdr_dat_q;
   logic [CTRL_W-1:0] hdr_ctrl_q;
   logic [TIME_W-1:0] hdr_time_q;
   logic [PORT_W-1:0] port_q;
   logic [BUF_W-1:0]  buf_q;
   entry_t            rd_entry, wr_entry;
   logic              tt_acc, eop_in, hdr_eop;
   logic              wrap, in_win, hit, early;
   logic              emit_hdr, fwd_word;

   assign wr_entry = '{valid:     in_table_valid,
                       port:      in_port_number,
                       buffer:    in_buffer_number,
                       win_start: in_window_start,
                       win_end:   in_window_end};

   // out_table_rdy stays low through reset via run_q, and during LOOKUP so the read is stable.
   assign out_table_rdy = run_q & (state_q != ST_LOOKUP);

   tt_window_table #(
      .FLOW_W  (FLOW_W),
      .entry_t (entry_t)
   ) u_table (
      .clk      (clk),
      .rst_n    (rst_n),
      .wr_en    (in_table_wr & out_table_rdy),
      .wr_addr  (in_table_flow),
      .wr_entry (wr_entry),
      .rd_addr  (hdr_dat_q[FLOW_W-1:0]),
      .rd_entry (rd_entry)
   );

   assign tt_acc  = in_tt_wr & out_tt_rdy;
   assign eop_in  = |in_tt_ctrl;
   assign hdr_eop = |hdr_ctrl_q;

   // A window with start > end wraps through zero; any miss on it is classed early.
   assign wrap   = rd_entry.win_start > rd_entry.win_end;
   assign in_win = wrap ? ((hdr_time_q >= rd_entry.win_start) || (hdr_time_q <= rd_entry.win_end))
                        : ((hdr_time_q >= rd_entry.win_start) && (hdr_time_q <= rd_entry.win_end));
   assign hit    = rd_entry.valid & in_win;
   assign early  = wrap | (hdr_time_q < rd_entry.win_start);

   always_comb begin
      state_d    = state_q;
      out_tt_rdy = 1'b0;
      out_drop   = 1'b0;
      emit_hdr   = 1'b0;
      fwd_word   = 1'b0;
      case (state_q)
         ST_IDLE: begin
            out_tt_rdy = run_q;
            if (tt_acc) state_d = ST_LOOKUP;
         end
         ST_LOOKUP: begin
            if (hit) begin
               state_d = ST_HEAD;
            end else begin
               out_drop = 1'b1;
               state_d  = hdr_eop ? ST_IDLE : ST_DROP;
            end
         end
         ST_HEAD: begin
            if (in_buffer_rdy) begin
               emit_hdr = 1'b1;
               state_d  = hdr_eop ? ST_IDLE : ST_FWD;
            end
         end
         ST_FWD: begin
            out_tt_rdy = in_buffer_rdy;
            if (tt_acc) begin
               fwd_word = 1'b1;
               if (eop_in) state_d = ST_IDLE;
            end
         end
         ST_DROP: begin
            out_tt_rdy = 1'b1;
            if (tt_acc && eop_in) state_d = ST_IDLE;
         end
         default: state_d = ST_IDLE;
      endcase
   end

   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         state_q         <= ST_IDLE;
         run_q           <= 1'b0;
         hdr_dat_q       <= '0;
         hdr_ctrl_q      <= '0;
         hdr_time_q      <= '0;
         port_q          <= '0;
         buf_q           <= '0;
         out_buffer_wr   <= 1'b0;
         out_buffer_data <= '0;
         out_buffer_ctrl <= '0;
      end else begin
         run_q         <= 1'b1;
         state_q       <= state_d;
         out_buffer_wr <= emit_hdr | fwd_word;
         if (state_q == ST_IDLE && tt_acc) begin
            hdr_dat_q  <= in_tt_data;
            hdr_ctrl_q <= in_tt_ctrl;
            hdr_time_q <= in_global_time;
         end
         if (state_q == ST_LOOKUP && hit) begin
            port_q <= rd_entry.port;
            buf_q  <= rd_entry.buffer;
         end
         if (emit_hdr) begin
            out_buffer_data <= hdr_dat_q;
            out_buffer_ctrl <= hdr_ctrl_q;
         end else if (fwd_word) begin
            out_buffer_data <= in_tt_data;
            out_buffer_ctrl <= in_tt_ctrl;
         end
      end
   end

   assign out_switch_port   = port_q;
   assign out_switch_buffer = buf_q;

`ifdef RX_WINDOW_STATS_EN
   localparam logic [CNT_W-1:0] CNT_ONE = {{(CNT_W-1){1'b0}}, 1'b1};

   logic [CNT_W-1:0] pass_q, early_q, late_q;
   logic             classify;

   assign classify = (state_q == ST_LOOKUP);

   // Invalid entries are dropped without touching either miss class.
   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         pass_q  <= '0;
         early_q <= '0;
         late_q  <= '0;
      end else if (classify) begin
         if (hit) begin
            if (!(&pass_q)) pass_q <= pass_q + CNT_ONE;
         end else if (rd_entry.valid) begin
            if (early) begin
               if (!(&early_q)) early_q <= early_q + CNT_ONE;
            end else begin
               if (!(&late_q)) late_q <= late_q + CNT_ONE;
            end
         end
      end
   end

   assign out_pass_cnt  = pass_q;
   assign out_early_cnt = early_q;
   assign out_late_cnt  = late_q;
`else
   logic unused_early;
   assign unused_early  = early;
   assign out_pass_cnt  = '0;
   assign out_early_cnt = '0;
   assign out_late_cnt  = '0;
`endif

endmodule

// File: tb/tb_tt_rx_window_filter.sv
// Scoreboard bench for tt_rx_window_filter: directed scenarios then randomized frames against a window model.
module tb_tt_rx_window_filter;

   localparam int DATA_W = 64, CTRL_W = 8, TIME_W = 64, FLOW_W = 4, PORT_W = 4, BUF_W = 4, CNT_W = 32;
`ifdef RX_WINDOW_STATS_EN
   localparam bit STATS = 1'b1;
`else
   localparam bit STATS = 1'b0;
`endif

   logic              clk, rst_n;
   logic [DATA_W-1:0] in_tt_data;
   logic [CTRL_W-1:0] in_tt_ctrl;
   logic              in_tt_wr, out_tt_rdy;
   logic [DATA_W-1:0] out_buffer_data;
   logic [CTRL_W-1:0] out_buffer_ctrl;
   logic              out_buffer_wr, in_buffer_rdy;
   logic [PORT_W-1:0] out_switch_port;
   logic [BUF_W-1:0]  out_switch_buffer;
   logic [TIME_W-1:0] in_global_time;
   logic              in_table_wr, out_table_rdy;
   logic [FLOW_W-1:0] in_table_flow;
   logic              in_table_valid;
   logic [PORT_W-1:0] in_port_number;
   logic [BUF_W-1:0]  in_buffer_number;
   logic [TIME_W-1:0] in_window_start, in_window_end;
   logic              out_drop;
   logic [CNT_W-1:0]  out_pass_cnt, out_early_cnt, out_late_cnt;

   tt_rx_window_filter dut (
      .clk(clk), .rst_n(rst_n),
      .in_tt_data(in_tt_data), .in_tt_ctrl(in_tt_ctrl), .in_tt_wr(in_tt_wr), .out_tt_rdy(out_tt_rdy),
      .out_buffer_data(out_buffer_data), .out_buffer_ctrl(out_buffer_ctrl), .out_buffer_wr(out_buffer_wr),
      .in_buffer_rdy(in_buffer_rdy), .out_switch_port(out_switch_port), .out_switch_buffer(out_switch_buffer),
      .in_global_time(in_global_time), .in_table_wr(in_table_wr), .out_table_rdy(out_table_rdy),
      .in_table_flow(in_table_flow), .in_table_valid(in_table_valid), .in_port_number(in_port_number),
      .in_buffer_number(in_buffer_number), .in_window_start(in_window_start), .in_window_end(in_window_end),
      .out_drop(out_drop), .out_pass_cnt(out_pass_cnt), .out_early_cnt(out_early_cnt), .out_late_cnt(out_late_cnt)
   );

   initial clk = 1'b0;
   always #5 clk = ~clk;

   typedef struct {
      logic              v;
      logic [PORT_W-1:0] p;
      logic [BUF_W-1:0]  b;
      logic [TIME_W-1:0] s, e;
   } ent_t;

   typedef struct {
      logic [DATA_W-1:0] d;
      logic [CTRL_W-1:0] c;
      logic [PORT_W-1:0] p;
      logic [BUF_W-1:0]  b;
   } exp_t;

   ent_t tbl [16];
   exp_t exp_q [$];
   int   n_tests = 0, n_fail = 0;
   int   exp_drops = 0, obs_drops = 0;
   int   exp_pass = 0, exp_early = 0, exp_late = 0;
   bit   bp_rand = 1'b0;

   task automatic check(input string name, input logic [63:0] act, input logic [63:0] req);
      n_tests++;
      if (act !== req) begin
         n_fail++;
         $display("FAIL %s: got %0h, required %0h", name, act, req);
      end
   endtask

   // Monitor: every forwarded word must match the head of the expected queue.
   always @(negedge clk) begin : mon
      exp_t e;
      if (out_drop === 1'b1) obs_drops++;
      if (out_buffer_wr === 1'b1) begin
         if (exp_q.size() == 0) begin
            n_tests++;
            n_fail++;
            $display("FAIL unexpected_word: got data %0h, required no word", out_buffer_data);
         end else begin
            e = exp_q.pop_front();
            check("fwd_data", out_buffer_data, e.d);
            check("fwd_ctrl", 64'(out_buffer_ctrl), 64'(e.c));
            check("fwd_port", 64'(out_switch_port), 64'(e.p));
            check("fwd_buf", 64'(out_switch_buffer), 64'(e.b));
         end
      end
   end

   always @(posedge clk) begin
      #1;
      if (bp_rand) in_buffer_rdy = ($urandom_range(0, 3) != 0);
   end

   // Reference: window rules applied directly to the table model at header time.
   task automatic model_lookup(input int flow, input logic [TIME_W-1:0] t, output bit hit);
      ent_t en = tbl[flow];
      bit   inwin;
      if (en.s <= en.e) inwin = (t >= en.s) && (t <= en.e);
      else              inwin = (t >= en.s) || (t <= en.e);
      hit = en.v && inwin;
      if (hit) exp_pass++;
      else begin
         exp_drops++;
         if (en.v) begin
            if (en.s > en.e || t < en.s) exp_early++;
            else                         exp_late++;
         end
      end
   endtask

   task automatic send_word(input logic [DATA_W-1:0] d, input logic [CTRL_W-1:0] c, output int waits);
      bit acc;
      in_tt_data = d;
      in_tt_ctrl = c;
      in_tt_wr   = 1'b1;
      waits      = 0;
      forever begin
         @(negedge clk);
         acc = out_tt_rdy;
         @(posedge clk);
         #1;
         if (acc) break;
         waits++;
         if (waits > 300) begin
            n_tests++;
            n_fail++;
            $display("FAIL word_accept_timeout: got no accept in %0d cycles, required accept", waits);
            break;
         end
      end
      in_tt_wr = 1'b0;
   endtask

   task automatic send_frame(input int flow, input int len, input logic [TIME_W-1:0] t, output int hwaits);
      logic [DATA_W-1:0] w [$];
      logic [CTRL_W-1:0] c [$];
      logic [DATA_W-1:0] d;
      bit                hit;
      int                wt;
      for (int i = 0; i < len; i++) begin
         d = {$urandom, $urandom};
         if (i == 0) d[FLOW_W-1:0] = FLOW_W'(flow);
         w.push_back(d);
         c.push_back((i == len - 1) ? CTRL_W'($urandom_range(1, 255)) : '0);
      end
      in_global_time = t;
      model_lookup(flow, t, hit);
      if (hit) for (int i = 0; i < len; i++) exp_q.push_back('{w[i], c[i], tbl[flow].p, tbl[flow].b});
      hwaits = 0;
      for (int i = 0; i < len; i++) begin
         send_word(w[i], c[i], wt);
         if (i == 0) hwaits = wt;
      end
   endtask

   task automatic table_write(input int f, input bit v, input logic [PORT_W-1:0] p, input logic [BUF_W-1:0] b,
                              input logic [TIME_W-1:0] s, input logic [TIME_W-1:0] e);
      bit acc;
      int n = 0;
      in_table_flow = FLOW_W'(f); in_table_valid = v; in_port_number = p; in_buffer_number = b;
      in_window_start = s; in_window_end = e; in_table_wr = 1'b1;
      forever begin
         @(negedge clk);
         acc = out_table_rdy;
         @(posedge clk);
         #1;
         if (acc) break;
         if (++n > 300) begin
            n_tests++;
            n_fail++;
            $display("FAIL table_write_timeout: got no accept, required accept");
            break;
         end
      end
      in_table_wr = 1'b0;
      if (acc) tbl[f] = '{v, p, b, s, e};
   endtask

   task automatic drain();
      int n = 0;
      while (exp_q.size() != 0 && n < 1000) begin
         @(posedge clk);
         #1;
         n++;
      end
      check("drain_queue_empty", 64'(exp_q.size()), 64'd0);
      exp_q.delete();
      repeat (4) @(posedge clk);
      #1;
   endtask

   task automatic check_stats(input string tag);
      check({tag, "_drops"}, 64'(obs_drops), 64'(exp_drops));
      check({tag, "_pass_cnt"}, 64'(out_pass_cnt), STATS ? 64'(exp_pass) : 64'd0);
      check({tag, "_early_cnt"}, 64'(out_early_cnt), STATS ? 64'(exp_early) : 64'd0);
      check({tag, "_late_cnt"}, 64'(out_late_cnt), STATS ? 64'(exp_late) : 64'd0);
   endtask

   task automatic check_all_zero(input string tag);
      check({tag, "_tt_rdy"}, 64'(out_tt_rdy), 64'd0);
      check({tag, "_table_rdy"}, 64'(out_table_rdy), 64'd0);
      check({tag, "_buffer_wr"}, 64'(out_buffer_wr), 64'd0);
      check({tag, "_buffer_data"}, out_buffer_data, 64'd0);
      check({tag, "_port"}, 64'({out_switch_port, out_switch_buffer}), 64'd0);
      check({tag, "_drop"}, 64'(out_drop), 64'd0);
      check({tag, "_cnts"}, 64'(out_pass_cnt | out_early_cnt | out_late_cnt), 64'd0);
   endtask

   task automatic model_reset();
      for (int i = 0; i < 16; i++) tbl[i] = '{1'b0, '0, '0, '0, '0};
      exp_q.delete();
      exp_drops = 0; obs_drops = 0; exp_pass = 0; exp_early = 0; exp_late = 0;
   endtask

   initial begin
      int   hw, hw2, n;
      bit   hit;
      logic [DATA_W-1:0] d;
      logic [TIME_W-1:0] s, e, t;

      rst_n = 1'b0; in_tt_data = '0; in_tt_ctrl = '0; in_tt_wr = 1'b0; in_buffer_rdy = 1'b1;
      in_global_time = '0; in_table_wr = 1'b0; in_table_flow = '0; in_table_valid = 1'b0;
      in_port_number = '0; in_buffer_number = '0; in_window_start = '0; in_window_end = '0;
      model_reset();
      #2;
      check_all_zero("reset");
      repeat (3) @(posedge clk);
      #1;
      rst_n = 1'b1;
      @(posedge clk);
      #1;
      check("idle_tt_rdy", 64'(out_tt_rdy), 64'd1);
      check("idle_table_rdy", 64'(out_table_rdy), 64'd1);

      // 1: in-window frame forwarded with entry's port/buffer
      table_write(3, 1'b1, 4'd3, 4'd2, 64'd10, 64'd50);
      send_frame(3, 4, 64'd20, hw);
      drain();
      check("t1_port", 64'(out_switch_port), 64'd3);
      check("t1_buf", 64'(out_switch_buffer), 64'd2);
      check_stats("t1");

      // 2: early and late drops, including window boundaries
      send_frame(3, 3, 64'd9, hw);
      send_frame(3, 2, 64'd51, hw);
      send_frame(3, 1, 64'd10, hw);
      send_frame(3, 2, 64'd50, hw);
      drain();
      check_stats("t2");

      // 3: wrap-around window
      table_write(5, 1'b1, 4'd6, 4'd1, 64'hFFFF_FFFF_FFFF_FFFB, 64'd4);
      send_frame(5, 3, 64'hFFFF_FFFF_FFFF_FFFF, hw);
      send_frame(5, 2, 64'd3, hw);
      send_frame(5, 2, 64'd100, hw);
      send_frame(7, 2, 64'd100, hw);
      drain();
      check_stats("t3");

      // 4: three-cycle stall mid-frame
      fork
         send_frame(3, 8, 64'd30, hw);
         begin
            n = 0;
            do begin @(negedge clk); n++; end while (out_buffer_wr !== 1'b1 && n < 100);
            @(posedge clk);
            #1;
            for (int i = 0; i < 3; i++) begin
               in_buffer_rdy = 1'b0;
               @(negedge clk);
               check("t4_rdy_follows_low", 64'(out_tt_rdy), 64'd0);
               @(posedge clk);
               #1;
            end
            in_buffer_rdy = 1'b1;
            @(negedge clk);
            check("t4_rdy_follows_high", 64'(out_tt_rdy), 64'd1);
         end
      join
      drain();

      // 5: zero-gap and single-word frames
      send_frame(3, 3, 64'd20, hw);
      send_frame(3, 2, 64'd21, hw);
      check("t5_zero_gap_hdr_wait", 64'(hw), 64'd0);
      send_frame(3, 1, 64'd22, hw);
      check("t5_after_fwd_hdr_wait", 64'(hw), 64'd0);
      send_frame(3, 1, 64'd23, hw2);
      check("t5_after_single_hdr_wait", 64'(hw2), 64'd2);
      send_frame(3, 1, 64'd5, hw);
      send_frame(3, 2, 64'd24, hw);
      drain();
      check("t5_idle_rdy", 64'(out_tt_rdy), 64'd1);
      check_stats("t5");

      // 6: table rewrite during FWD, then reset mid-frame
      fork
         send_frame(3, 6, 64'd30, hw);
         begin
            n = 0;
            do begin @(negedge clk); n++; end while (out_buffer_wr !== 1'b1 && n < 100);
            @(posedge clk);
            #1;
            table_write(3, 1'b1, 4'd7, 4'd5, 64'd0, 64'hFFFF_FFFF_FFFF_FFFF);
         end
      join
      send_frame(3, 2, 64'd1000, hw);
      drain();
      check("t6_new_port", 64'(out_switch_port), 64'd7);
      check("t6_new_buf", 64'(out_switch_buffer), 64'd5);
      check_stats("t6");

      in_global_time = 64'd40;
      model_lookup(3, 64'd40, hit);
      for (int i = 0; i < 3; i++) begin
         d = {$urandom, $urandom};
         if (i == 0) d[FLOW_W-1:0] = 4'd3;
         if (hit) exp_q.push_back('{d, 8'd0, tbl[3].p, tbl[3].b});
         send_word(d, 8'd0, hw);
      end
      drain();
      rst_n = 1'b0;
      #1;
      check_all_zero("midfwd_reset");
      model_reset();
      repeat (3) @(posedge clk);
      #1;
      rst_n = 1'b1;
      repeat (3) @(posedge clk);
      #1;
      table_write(3, 1'b1, 4'd3, 4'd2, 64'd10, 64'd50);
      send_frame(3, 4, 64'd20, hw);
      drain();
      check_stats("resend");

      // Randomized frames, tables and backpressure
      bp_rand = 1'b1;
      for (int f = 0; f < 16; f++) begin
         s = {$urandom, $urandom};
         if ($urandom_range(0, 2) == 0) begin
            s = 64'hFFFF_FFFF_FFFF_FFFF - 64'($urandom_range(0, 500));
            e = 64'($urandom_range(0, 500));
         end else begin
            s = {1'b0, s[62:0]};
            e = s + 64'($urandom_range(0, 1000));
         end
         table_write(f, $urandom_range(0, 5) != 0, 4'($urandom), 4'($urandom), s, e);
      end
      for (int k = 0; k < 60; k++) begin
         n = $urandom_range(0, 15);
         case ($urandom_range(0, 4))
            0:       t = tbl[n].s;
            1:       t = tbl[n].s - 64'd1;
            2:       t = tbl[n].e;
            3:       t = tbl[n].e + 64'd1;
            default: t = {$urandom, $urandom};
         endcase
         send_frame(n, $urandom_range(1, 6), t, hw);
         if ($urandom_range(0, 7) == 0)
            table_write($urandom_range(0, 15), 1'b1, 4'($urandom), 4'($urandom), 64'd0, 64'($urandom));
         repeat ($urandom_range(0, 2)) @(posedge clk);
         #1;
      end
      bp_rand = 1'b0;
      @(posedge clk);
      #1;
      in_buffer_rdy = 1'b1;
      drain();
      check_stats("random");

      $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
      $finish;
   end

endmodule
